// File: rtl/mod_counter_pkg.sv
// Shared constants for the modulo-N up/down counter family: default sizing
// and the direction encoding on the mode pin.
package mod_counter_pkg;

  localparam int unsigned DEF_MOD = 14;
  localparam int unsigned DEF_W   = 4;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/modn_step.sv
// Combinational next-count and wrap decode for a modulo-MOD counter.
// Wrap is detected by comparison against the end values, never by overflow.
module modn_step
  import mod_counter_pkg::*;
#(
  parameter int unsigned MOD = DEF_MOD,
  parameter int unsigned W   = DEF_W
) (
  input  logic [W-1:0] cur,
  input  logic         mode,
  output logic [W-1:0] nxt,
  output logic         wraps
);

  localparam logic [W-1:0] TOP = W'(MOD - 1);

  always_comb begin
    nxt   = cur;
    wraps = 1'b0;
    if (mode == UP) begin
      if (cur == TOP) begin
        nxt   = '0;
        wraps = 1'b1;
      end else begin
        nxt = cur + 1'b1;
      end
    end else begin
      if (cur == '0) begin
        nxt   = TOP;
        wraps = 1'b1;
      end else begin
        nxt = cur - 1'b1;
      end
    end
  end

endmodule

// File: rtl/modn_updown_counter.sv
// Modulo-MOD up/down counter with parallel load, registered wrap and
// load-error pulses, and a combinational terminal count for cascading.
module modn_updown_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned MOD = DEF_MOD,
  parameter int unsigned W   = DEF_W
) (
  input  logic         clock,
  input  logic         rest,
  input  logic         en,
  input  logic         mode,
  input  logic         load,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic         tc,
  output logic         wrap,
  output logic         load_err
);

  generate
    if (MOD < 2 || (64'd1 << W) < 64'(MOD)) begin : g_bad_param
      $error("modn_updown_counter: MOD must satisfy 2 <= MOD <= 2**W");
    end
  endgenerate

  localparam logic [W-1:0] TOP     = W'(MOD - 1);
  localparam logic [W:0]   MOD_EXT = (W + 1)'(MOD);

  logic [W-1:0] step_nxt;
  logic         step_wraps;
  logic         load_ok;
  logic [W-1:0] cnt_d;
  logic         wrap_d;
  logic         err_d;

  modn_step #(
    .MOD (MOD),
    .W   (W)
  ) u_step (
    .cur   (data_out),
    .mode  (mode),
    .nxt   (step_nxt),
    .wraps (step_wraps)
  );

  // Extra top bit keeps the range check exact when MOD == 2**W.
  assign load_ok = ({1'b0, data_in} < MOD_EXT);

  always_comb begin
    cnt_d  = data_out;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      if (load_ok) cnt_d = data_in;
      else         err_d = 1'b1;
    end else if (en) begin
      cnt_d  = step_nxt;
      wrap_d = step_wraps;
    end
  end

  always_ff @(posedge clock) begin
    if (rest) begin
      data_out <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      data_out <= cnt_d;
      wrap     <= wrap_d;
      load_err <= err_d;
    end
  end

  assign tc = en & (((mode == UP) & (data_out == TOP)) |
                    ((mode == DOWN) & (data_out == '0)));

endmodule

// File: tb/tb_modn_updown_counter.sv
// Bench for modn_updown_counter: directed and random checks of a MOD=14
// counter, a two-digit decimal cascade and a MOD=16 free-running instance.
module tb_modn_updown_counter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Instance counting modulo 14
  logic       rest_a, en_a, mode_a, load_a;
  logic [3:0] din_a, dout_a;
  logic       tc_a, wrap_a, err_a;

  modn_updown_counter #(.MOD(14), .W(4)) dut_a (
    .clock(clock), .rest(rest_a), .en(en_a), .mode(mode_a), .load(load_a),
    .data_in(din_a), .data_out(dout_a), .tc(tc_a), .wrap(wrap_a), .load_err(err_a)
  );

  // Decimal cascade, modulo 10 per digit: units tc drives tens en
  logic       rest_b;
  logic       en_u;
  logic [3:0] dout_u, dout_t;
  logic       tc_u, tc_t, wrap_u, wrap_t, err_u, err_t;

  modn_updown_counter #(.MOD(10), .W(4)) dut_units (
    .clock(clock), .rest(rest_b), .en(en_u), .mode(1'b1), .load(1'b0),
    .data_in(4'd0), .data_out(dout_u), .tc(tc_u), .wrap(wrap_u), .load_err(err_u)
  );
  modn_updown_counter #(.MOD(10), .W(4)) dut_tens (
    .clock(clock), .rest(rest_b), .en(tc_u), .mode(1'b1), .load(1'b0),
    .data_in(4'd0), .data_out(dout_t), .tc(tc_t), .wrap(wrap_t), .load_err(err_t)
  );

  // Free-running instance counting modulo 16
  logic       rest_c;
  logic [3:0] dout_c;
  logic       tc_c, wrap_c, err_c;

  modn_updown_counter #(.MOD(16), .W(4)) dut_c (
    .clock(clock), .rest(rest_c), .en(1'b1), .mode(1'b1), .load(1'b0),
    .data_in(4'd0), .data_out(dout_c), .tc(tc_c), .wrap(wrap_c), .load_err(err_c)
  );

  // Reference model of the MOD=14 counter, in plain integer arithmetic
  localparam int M = 14;
  int m_cnt = 0;
  int m_wrap = 0;
  int m_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge(input int r, input int l, input int d, input int e, input int m);
    if (r != 0) begin
      m_cnt = 0; m_wrap = 0; m_err = 0;
    end else if (l != 0) begin
      m_wrap = 0;
      m_err  = (d >= M) ? 1 : 0;
      if (d < M) m_cnt = d;
    end else if (e != 0) begin
      m_err = 0;
      if (m != 0) begin
        m_wrap = (m_cnt == M - 1) ? 1 : 0;
        m_cnt  = (m_cnt + 1) % M;
      end else begin
        m_wrap = (m_cnt == 0) ? 1 : 0;
        m_cnt  = (m_cnt + M - 1) % M;
      end
    end else begin
      m_wrap = 0; m_err = 0;
    end
  endtask

  // Drive inputs at negedge, check tc, advance one edge, check registers.
  task automatic step_a(input string tag, input int r, input int l, input int d,
                        input int e, input int m);
    int exp_tc;
    rest_a = 1'(r); load_a = 1'(l); din_a = 4'(d); en_a = 1'(e); mode_a = 1'(m);
    #1;
    exp_tc = (e != 0) && ((m != 0) ? (m_cnt == M - 1) : (m_cnt == 0));
    if (r == 0) chk({tag, ".tc"}, 32'(tc_a), 32'(exp_tc));
    @(posedge clock);
    model_edge(r, l, d, e, m);
    @(negedge clock);
    chk({tag, ".data_out"}, 32'(dout_a), 32'(m_cnt));
    chk({tag, ".wrap"},     32'(wrap_a), 32'(m_wrap));
    chk({tag, ".load_err"}, 32'(err_a),  32'(m_err));
  endtask

  initial begin
    rest_a = 1'b1; en_a = 1'b0; mode_a = 1'b1; load_a = 1'b0; din_a = '0;
    rest_b = 1'b1; en_u = 1'b0;
    rest_c = 1'b1;
    @(negedge clock);

    // Reset, including reset overriding a concurrent load and enable
    step_a("reset0", 1, 0, 0, 0, 1);
    step_a("reset1", 1, 1, 3, 1, 1);

    // Up count 0..13 then back to 0
    for (int i = 0; i < 15; i++) step_a("up", 0, 0, 0, 1, 1);

    // Down from 0 wraps to 13, then 12
    step_a("dn_rst", 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step_a("down", 0, 0, 0, 1, 0);

    // Loads: legal value, then two out-of-range values
    step_a("load9", 0, 1, 9, 0, 1);
    step_a("load14", 0, 1, 14, 1, 1);
    step_a("hold", 0, 0, 0, 0, 1);
    step_a("load15", 0, 1, 15, 0, 0);
    step_a("hold2", 0, 0, 0, 0, 0);

    // Count to 7, then reset together with a load
    step_a("pre_rst", 1, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) step_a("to7", 0, 0, 0, 1, 1);
    step_a("rst_load", 1, 1, 3, 1, 1);
    step_a("resume", 0, 0, 0, 1, 1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step_a("rand", ($urandom_range(0, 15) == 0) ? 1 : 0,
             ($urandom_range(0, 3) == 0) ? 1 : 0,
             int'($urandom_range(0, 15)),
             ($urandom_range(0, 3) != 0) ? 1 : 0,
             int'($urandom_range(0, 1)));
    end
    rest_a = 1'b0; en_a = 1'b0; load_a = 1'b0;

    // Decimal cascade 00..99 and rollover
    @(posedge clock);
    @(negedge clock);
    rest_b = 1'b0; en_u = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      #1;
      chk("bcd.value", 32'(int'(dout_t) * 10 + int'(dout_u)), 32'(i % 100));
      chk("bcd.tens_tc", 32'(tc_t), 32'((i % 100) == 99));
      chk("bcd.units_wrap", 32'(wrap_u), 32'((i % 10 == 0) && (i > 0)));
      @(negedge clock);
    end
    en_u = 1'b0;

    // Free-running modulo-16 up count through 15 -> 0
    rest_c = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clock);
      chk("m16.value", 32'(dout_c), 32'(i % 16));
      chk("m16.wrap",  32'(wrap_c), 32'(i == 16));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
